// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates trap, mem_busy, branch and load-use into stall/flush/redirect.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int XLEN   = 64,
  parameter int NSTAGE = 6,
  parameter int EX_IDX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_target,
  input  logic              mem_busy,
  input  logic              branch_taken_EXB,
  input  logic [XLEN-1:0]   branch_target_EXB,
  input  logic              no_forwarding_data,
  input  logic              ifp_ready,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_target,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  typedef enum logic {
    IDLE,
    PEND
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              pend;
  logic [NSTAGE-1:0] stallRaw, flushRaw;

  assign pend = (state_q == PEND);

  // Event arbitration: trap > mem_busy > branch > load-use; a pending redirect also blocks fetch.
  always_comb begin
    stallRaw        = '0;
    flushRaw        = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    if (trap_valid) begin
      for (int i = 1; i < NSTAGE; i++) flushRaw[i] = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = trap_target;
    end else if (mem_busy) begin
      stallRaw = '1;
    end else if (branch_taken_EXB && !pend) begin
      for (int i = 1; i <= EX_IDX; i++) flushRaw[i] = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = branch_target_EXB;
    end else if (no_forwarding_data) begin
      for (int i = 0; i < EX_IDX; i++) stallRaw[i] = 1'b1;
      flushRaw[EX_IDX] = 1'b1;
    end
    if (pend) begin
      flushRaw[1:0] = 2'b11;
      if (!trap_valid) begin
        redirect_valid  = 1'b1;
        redirect_target = target_q;
      end
    end
    stall = stallRaw & ~flushRaw;
    flush = flushRaw;
    if (!rst_n) begin
      stall           = '0;
      flush           = '1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (redirect_valid) begin
      if (ifp_ready) begin
        state_d = IDLE;
      end else begin
        state_d  = PEND;
        target_d = redirect_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;
  logic [31:0] flushCnt_q, flushCnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if ((|stall) && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_d = stallCnt_q + 32'd1;
    if (redirect_valid && ifp_ready && (flushCnt_q != 32'hFFFF_FFFF)) flushCnt_d = flushCnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign perf_stall_cnt = stallCnt_q;
  assign perf_flush_cnt = flushCnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RVCPU in-order core. It arbitrates four hazard sources: trap redirect, data-memory busy, branch taken in EXB, and the missing-forwarding stall. From them it produces per-stage stall/flush vectors and a fetch redirect. A redirect that fetch cannot accept is held in a pending register until the IFP handshake completes. It sits beside the pipeline registers and drives every stage's stall/flush inputs and the IFP redirect port.

## Interface
- `XLEN`, 64: address width of redirect targets.
- `NSTAGE`, 6: number of pipeline register stages. Bit 0 = IFP, 1 = IFR, 2 = IDC, 3 = IDR, 4 = EXB, 5 = MEM; higher bits are later stages.
- `EX_IDX`, 4: stage index where branches resolve; 1 ≤ `EX_IDX` < `NSTAGE`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `trap_valid` in 1: exception/interrupt commits this cycle.
- `trap_target` in XLEN: trap vector address.
- `mem_busy` in 1: data memory has not completed; freeze the whole pipe.
- `branch_taken_EXB` in 1: taken branch/jump resolved in EXB.
- `branch_target_EXB` in XLEN: its target.
- `no_forwarding_data` in 1: load-use hazard; operand not forwardable.
- `ifp_ready` in 1: IFP accepts a redirect this cycle.
- `stall` out NSTAGE: per-stage hold.
- `flush` out NSTAGE: per-stage bubble insert.
- `redirect_valid` out 1: redirect offered to IFP.
- `redirect_target` out XLEN: redirect PC.
- `perf_stall_cnt` out 32: cycles with any stall bit set.
- `perf_flush_cnt` out 32: redirect events accepted.

## Operation
- Event priority per cycle: trap > mem_busy > branch > load-use. Lower-priority events that lose arbitration have no effect.
- Trap:
  - flush[NSTAGE-1:1] = 1, stall = 0.
  - Redirect to `trap_target`.
- mem_busy (no trap):
  - stall = all ones, flush = 0.
  - Branch and load-use are ignored. They re-present next cycle because EXB is held.
- Branch (no trap, no mem_busy):
  - flush[EX_IDX:1] = 1, stall = 0.
  - Redirect to `branch_target_EXB`.
- Load-use only:
  - stall[EX_IDX-1:0] = 1.
  - flush[EX_IDX] = 1, which puts a bubble into EXB.
  - Later stages proceed.
- Redirect handshake:
  - `redirect_valid`/`redirect_target` are driven combinationally in the event cycle.
  - If `ifp_ready` = 1 in that cycle, the redirect completes and the FSM stays IDLE.
  - Otherwise the target latches and the FSM enters PEND.
- FSM states:
  - IDLE → PEND on a redirect with `ifp_ready` = 0.
  - PEND → IDLE on `ifp_ready` = 1.
  - PEND → PEND otherwise.
- In PEND:
  - `redirect_valid` = 1 and `redirect_target` = the latched value.
  - flush[1:0] = 1, so no wrong-path fetch enters.
  - Other bits follow the rules above.
  - A branch in PEND is ignored, because EXB holds only bubbles.
  - A trap in PEND overwrites the latched target. It presents `trap_target` combinationally that cycle.
- Simultaneous stall and flush on one stage never occurs. If they conflict, flush wins.

## Timing
- All stall/flush/redirect outputs are combinational from inputs plus FSM state. Zero-cycle latency.
- Pending register and FSM update on the `clk` rising edge.
- Reset (`rst_n` = 0 at a clock edge): FSM → IDLE, latched target → 0, counters → 0.
- While `rst_n` = 0: flush = all ones, stall = 0, `redirect_valid` = 0, `redirect_target` = 0.
- Reset during PEND discards the pending redirect with no handshake.
- A redirect accepted in cycle N: IFP fetches the target in N+1. The FSM is IDLE in N+1.
- A redirect held for k cycles: `redirect_valid` stays high for k+1 cycles total. The target is stable unless a trap overrides it.
- Counters:
  - `perf_stall_cnt` increments on any cycle where stall ≠ 0 and `rst_n` = 1.
  - `perf_flush_cnt` increments on each cycle where `redirect_valid` & `ifp_ready`.
  - Both saturate at 0xFFFF_FFFF and never wrap.

## Configuration
- `HAZARD_PERF_CNT_EN`:
  - Defined: both 32-bit saturating counters are implemented as specified.
  - Undefined: counter registers are omitted and `perf_stall_cnt` = `perf_flush_cnt` = 0 constantly.
  - Ports exist in both cases.

## Test plan
- Defaults. `no_forwarding_data` = 1 for 2 cycles → stall = 6'b001111 and flush = 6'b010000 both cycles; `perf_stall_cnt` = 2.
- `branch_taken_EXB` = 1, target 0x8000_0040, `ifp_ready` = 1 → flush = 6'b011110 and redirect 0x8000_0040 in the same cycle; FSM IDLE next cycle; `perf_flush_cnt` = 1.
- Branch to 0x100 with `ifp_ready` = 0 for 3 cycles, then 1:
  - `redirect_valid` high for 4 cycles, target 0x100 throughout.
  - flush[1:0] = 2'b11 in the 3 PEND cycles.
  - Handshake completes on the 4th cycle.
- During PEND (target 0x100), `trap_valid` = 1 with `trap_target` 0x200 and `ifp_ready` = 0 → target becomes 0x200 that cycle; the next cycle still presents 0x200.
- `mem_busy` = 1, `branch_taken_EXB` = 1 and `no_forwarding_data` = 1 together → stall = 6'b111111, flush = 0, `redirect_valid` = 0.
- `rst_n` = 0 during PEND → next cycle `redirect_valid` = 0, flush = all ones, counters = 0. With the macro undefined, counters read 0 throughout.
